// File: rtl/reg_master_pkg.sv
// Shared definitions for the register-bus initiator: op codes, the register
// offsets also used by the responder, and the controller state encoding.
package reg_master_pkg;

  localparam logic [7:0] CTRL_ADDR   = 8'h00;
  localparam logic [7:0] STATUS_ADDR = 8'h04;

  typedef enum logic [1:0] {
    OP_WR   = 2'b00,
    OP_RD   = 2'b01,
    OP_POLL = 2'b10,
    OP_BAD  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    GAP    = 2'b10,
    RESP   = 2'b11
  } state_e;

endpackage

// File: rtl/reg_master_if.sv
// Command, response and register-bus signals of reg_master bundled together;
// the master modport is the initiator's view, slave is the environment's view.
interface reg_master_if #(
  parameter int AW = 8,
  parameter int DW = 32
);

  logic          cmd_valid_i;
  logic          cmd_ready_o;
  logic [1:0]    cmd_op_i;
  logic [AW-1:0] cmd_addr_i;
  logic [DW-1:0] cmd_data_i;
  logic [DW-1:0] cmd_mask_i;
  logic          rsp_valid_o;
  logic          rsp_ready_i;
  logic [DW-1:0] rsp_data_o;
  logic          rsp_err_o;
  logic [AW-1:0] addr_o;
  logic [DW-1:0] wr_data_o;
  logic          wr_en_o;
  logic          rd_en_o;
  logic [DW-1:0] rd_data_i;

  modport master (
    input  cmd_valid_i, cmd_op_i, cmd_addr_i, cmd_data_i, cmd_mask_i,
    input  rsp_ready_i, rd_data_i,
    output cmd_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o,
    output addr_o, wr_data_o, wr_en_o, rd_en_o
  );

  modport slave (
    output cmd_valid_i, cmd_op_i, cmd_addr_i, cmd_data_i, cmd_mask_i,
    output rsp_ready_i, rd_data_i,
    input  cmd_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o,
    input  addr_o, wr_data_o, wr_en_o, rd_en_o
  );

endinterface

// File: rtl/reg_master.sv
// Command-driven register-bus initiator: runs one write, read or poll command
// at a time and returns read data or status on a valid/ready response channel.
import reg_master_pkg::*;

module reg_master #(
  parameter int AW        = 8,
  parameter int DW        = 32,
  parameter int POLL_GAP  = 4,
  parameter int MAX_POLLS = 1000,
  parameter int CNT_W     = 16
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  reg_master_if.master  bus
);

  state_e        state_q, state_d;
  op_e           op_q, op_d;
  logic [DW-1:0] data_q, data_d;
  logic [DW-1:0] mask_q, mask_d;
  logic [CNT_W-1:0] attempts_q, attempts_d;
  logic [CNT_W-1:0] gap_q, gap_d;
  logic          cmd_ready_q, cmd_ready_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [DW-1:0] rsp_data_q, rsp_data_d;
  logic          rsp_err_q, rsp_err_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wr_data_q, wr_data_d;
  logic          wr_en_q, wr_en_d;
  logic          rd_en_q, rd_en_d;

  logic [CNT_W-1:0] attempts_inc;
  logic             poll_match;

  // The attempt count stops at MAX_POLLS so a long poll can never wrap around.
  assign attempts_inc = (attempts_q >= CNT_W'(MAX_POLLS)) ? attempts_q
                                                          : attempts_q + 1'b1;
  assign poll_match   = ((bus.rd_data_i ^ data_q) & mask_q) == '0;

  // Outputs are computed one cycle ahead so every port comes straight from a flop.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    data_d      = data_q;
    mask_d      = mask_q;
    attempts_d  = attempts_q;
    gap_d       = gap_q;
    cmd_ready_d = cmd_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    addr_d      = addr_q;
    wr_data_d   = wr_data_q;
    wr_en_d     = 1'b0;
    rd_en_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        cmd_ready_d = 1'b1;
        if (bus.cmd_valid_i && cmd_ready_q) begin
          op_d        = op_e'(bus.cmd_op_i);
          addr_d      = bus.cmd_addr_i;
          data_d      = bus.cmd_data_i;
          mask_d      = bus.cmd_mask_i;
          attempts_d  = '0;
          gap_d       = '0;
          cmd_ready_d = 1'b0;
          if (op_e'(bus.cmd_op_i) == OP_BAD) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_data_d  = '0;
          end else begin
            state_d = ACCESS;
            wr_en_d = (op_e'(bus.cmd_op_i) == OP_WR);
            rd_en_d = (op_e'(bus.cmd_op_i) != OP_WR);
            if (op_e'(bus.cmd_op_i) == OP_WR) wr_data_d = bus.cmd_data_i;
          end
        end
      end
      ACCESS: begin
        rsp_err_d = 1'b0;
        unique case (op_q)
          OP_WR: begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_data_d  = '0;
          end
          OP_RD: begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_data_d  = bus.rd_data_i;
          end
          OP_POLL: begin
            rsp_data_d = bus.rd_data_i;
            attempts_d = attempts_inc;
            if (poll_match) begin
              state_d     = RESP;
              rsp_valid_d = 1'b1;
            end else if (attempts_inc == CNT_W'(MAX_POLLS)) begin
              state_d     = RESP;
              rsp_valid_d = 1'b1;
              rsp_err_d   = 1'b1;
            end else begin
              state_d = GAP;
              gap_d   = '0;
            end
          end
          default: begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end
        endcase
      end
      GAP: begin
        if (gap_q == CNT_W'(POLL_GAP - 1)) begin
          state_d = ACCESS;
          rd_en_d = 1'b1;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      RESP: begin
        if (bus.rsp_ready_i) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      op_q        <= OP_WR;
      data_q      <= '0;
      mask_q      <= '0;
      attempts_q  <= '0;
      gap_q       <= '0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      addr_q      <= '0;
      wr_data_q   <= '0;
      wr_en_q     <= 1'b0;
      rd_en_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      data_q      <= data_d;
      mask_q      <= mask_d;
      attempts_q  <= attempts_d;
      gap_q       <= gap_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      addr_q      <= addr_d;
      wr_data_q   <= wr_data_d;
      wr_en_q     <= wr_en_d;
      rd_en_q     <= rd_en_d;
    end
  end

  assign bus.cmd_ready_o = cmd_ready_q;
  assign bus.rsp_valid_o = rsp_valid_q;
  assign bus.rsp_data_o  = rsp_data_q;
  assign bus.rsp_err_o   = rsp_err_q;
  assign bus.addr_o      = addr_q;
  assign bus.wr_data_o   = wr_data_q;
  assign bus.wr_en_o     = wr_en_q;
  assign bus.rd_en_o     = rd_en_q;

endmodule

// File: tb/tb_reg_master.sv
// Bench for reg_master: a behavioural register responder on the bus side and a
// command-level model predicting response data, error, latency and strobe counts.
import reg_master_pkg::*;

module tb_reg_master;

  localparam int GAP  = 4;
  localparam int MAXP = 3;

  logic clk = 1'b0;
  logic rst_n;

  int checks = 0;
  int errors = 0;

  logic [31:0] model_mem [256];
  logic [31:0] resp_mem  [256];
  logic [31:0] status_val;

  reg_master_if #(.AW(8), .DW(32)) bus_if ();

  reg_master #(
    .AW(8), .DW(32), .POLL_GAP(GAP), .MAX_POLLS(MAXP), .CNT_W(16)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus_if)
  );

  always #5 clk = ~clk;

  // Responder: plain register file, with the status offset fed from the bench.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) resp_mem[i] <= '0;
    end else if (bus_if.wr_en_o) begin
      resp_mem[bus_if.addr_o] <= bus_if.wr_data_o;
    end
  end

  assign bus_if.rd_data_i = (bus_if.addr_o == STATUS_ADDR) ? status_val
                                                           : resp_mem[bus_if.addr_o];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One command end to end: predict, issue, watch the bus, then retire it.
  task automatic apply_stimulus(input string tag, input logic [1:0] op,
                                input logic [7:0] addr, input logic [31:0] data,
                                input logic [31:0] mask, input int raise_at,
                                input logic [31:0] raise_val, input int hold,
                                input bit early_ready);
    int exp_nwr, exp_nrd, exp_lat;
    logic exp_err;
    logic [31:0] exp_data, v;
    int cyc, nrd, nwr, both, rsp_cyc, w;

    exp_nwr = 0; exp_nrd = 0; exp_lat = 2; exp_err = 1'b0; exp_data = '0;
    case (op)
      2'b00: exp_nwr = 1;
      2'b01: begin
        exp_nrd  = 1;
        exp_data = (addr == STATUS_ADDR) ? status_val : model_mem[addr];
      end
      2'b10: begin
        for (int k = 1; k <= MAXP; k++) begin
          int c;
          c = 1 + (k - 1) * (GAP + 1);
          if (addr != STATUS_ADDR) v = model_mem[addr];
          else if (raise_at >= 0 && c >= raise_at) v = raise_val;
          else v = status_val;
          exp_nrd  = k;
          exp_lat  = c + 1;
          exp_data = v;
          if (((v ^ data) & mask) == 32'h0) begin
            exp_err = 1'b0;
            break;
          end
          exp_err = (k == MAXP);
        end
      end
      default: begin exp_lat = 1; exp_err = 1'b1; end
    endcase

    bus_if.cmd_valid_i = 1'b1;
    bus_if.cmd_op_i    = op;
    bus_if.cmd_addr_i  = addr;
    bus_if.cmd_data_i  = data;
    bus_if.cmd_mask_i  = mask;
    bus_if.rsp_ready_i = early_ready;
    w = 0;
    while (!bus_if.cmd_ready_o && w < 50) begin tick(); w++; end
    check_output({tag, "_cmd_ready"}, bus_if.cmd_ready_o, 1'b1);
    tick();
    bus_if.cmd_valid_i = 1'b0;
    bus_if.cmd_op_i    = 2'($urandom);

    cyc = 1; nrd = 0; nwr = 0; both = 0; rsp_cyc = -1;
    while (cyc < 100) begin
      if (cyc == raise_at) status_val = raise_val;
      if (bus_if.rd_en_o && bus_if.wr_en_o) both++;
      if (bus_if.rd_en_o) begin
        check_output({tag, "_rd_cycle"}, cyc, 1 + nrd * (GAP + 1));
        check_output({tag, "_rd_addr"}, {24'h0, bus_if.addr_o}, {24'h0, addr});
        nrd++;
      end
      if (bus_if.wr_en_o) begin
        check_output({tag, "_wr_cycle"}, cyc, 1);
        check_output({tag, "_wr_addr"}, {24'h0, bus_if.addr_o}, {24'h0, addr});
        check_output({tag, "_wr_data"}, bus_if.wr_data_o, data);
        nwr++;
      end
      if (bus_if.rsp_valid_o) begin rsp_cyc = cyc; break; end
      tick();
      cyc++;
    end
    check_output({tag, "_latency"}, rsp_cyc, exp_lat);
    check_output({tag, "_n_rd"}, nrd, exp_nrd);
    check_output({tag, "_n_wr"}, nwr, exp_nwr);
    check_output({tag, "_overlap"}, both, 0);
    check_output({tag, "_rsp_data"}, bus_if.rsp_data_o, exp_data);
    check_output({tag, "_rsp_err"}, bus_if.rsp_err_o, exp_err);
    check_output({tag, "_busy_ready"}, bus_if.cmd_ready_o, 1'b0);

    if (!early_ready) begin
      for (int h = 0; h < hold; h++) begin
        tick();
        check_output({tag, "_hold_valid"}, bus_if.rsp_valid_o, 1'b1);
        check_output({tag, "_hold_data"}, bus_if.rsp_data_o, exp_data);
        check_output({tag, "_hold_err"}, bus_if.rsp_err_o, exp_err);
        check_output({tag, "_hold_busy"}, bus_if.cmd_ready_o, 1'b0);
        check_output({tag, "_hold_strobe"}, bus_if.rd_en_o | bus_if.wr_en_o, 1'b0);
      end
      bus_if.rsp_ready_i = 1'b1;
    end
    tick();
    bus_if.rsp_ready_i = 1'b0;
    check_output({tag, "_rsp_drop"}, bus_if.rsp_valid_o, 1'b0);
    check_output({tag, "_next_ready"}, bus_if.cmd_ready_o, 1'b1);

    if (op == 2'b00) model_mem[addr] = data;
  endtask

  initial begin
    logic [7:0]  a;
    logic [31:0] d, m;
    int r, b2b_wait;

    for (int i = 0; i < 256; i++) model_mem[i] = '0;
    status_val         = '0;
    rst_n              = 1'b0;
    bus_if.cmd_valid_i = 1'b0;
    bus_if.cmd_op_i    = 2'b00;
    bus_if.cmd_addr_i  = '0;
    bus_if.cmd_data_i  = '0;
    bus_if.cmd_mask_i  = '0;
    bus_if.rsp_ready_i = 1'b0;

    #12;
    check_output("reset_cmd_ready", bus_if.cmd_ready_o, 1'b0);
    check_output("reset_rsp_valid", bus_if.rsp_valid_o, 1'b0);
    check_output("reset_strobes", {30'h0, bus_if.wr_en_o, bus_if.rd_en_o}, 32'h0);
    check_output("reset_addr", {24'h0, bus_if.addr_o}, 32'h0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    check_output("post_reset_ready", bus_if.cmd_ready_o, 1'b1);
    check_output("post_reset_valid", bus_if.rsp_valid_o, 1'b0);

    $display("[TB] directed write/read/poll/illegal");
    apply_stimulus("wr_ctrl", 2'b00, CTRL_ADDR, 32'hDEADBEEF, 32'h0, -1, 32'h0, 0, 1'b0);
    check_output("ctrl_reg", resp_mem[CTRL_ADDR], 32'hDEADBEEF);
    apply_stimulus("rd_ctrl", 2'b01, CTRL_ADDR, 32'h0, 32'h0, -1, 32'h0, 0, 1'b0);
    status_val = 32'h0;
    apply_stimulus("poll_raise", 2'b10, STATUS_ADDR, 32'h1, 32'h1, 10, 32'h1, 0, 1'b0);
    status_val = 32'hA0;
    apply_stimulus("poll_timeout", 2'b10, STATUS_ADDR, 32'h1, 32'h1, -1, 32'h0, 0, 1'b0);
    apply_stimulus("illegal_hold", 2'b11, 8'h10, 32'h1234, 32'h0, -1, 32'h0, 5, 1'b0);
    apply_stimulus("poll_mask0", 2'b10, STATUS_ADDR, 32'hFFFF, 32'h0, -1, 32'h0, 0, 1'b0);
    apply_stimulus("rd_early", 2'b01, CTRL_ADDR, 32'h0, 32'h0, -1, 32'h0, 0, 1'b1);

    $display("[TB] randomized commands");
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 10);
      a = 8'($urandom_range(0, 255));
      if (a == STATUS_ADDR) a = 8'h08;
      d = $urandom;
      m = $urandom;
      if (r <= 3)      apply_stimulus("rnd_wr", 2'b00, a, d, m, -1, 32'h0, $urandom_range(0, 2), 1'($urandom));
      else if (r <= 6) apply_stimulus("rnd_rd", 2'b01, a, d, m, -1, 32'h0, $urandom_range(0, 2), 1'($urandom));
      else if (r == 7) apply_stimulus("rnd_poll0", 2'b10, a, d, 32'h0, -1, 32'h0, 0, 1'($urandom));
      else if (r == 8) apply_stimulus("rnd_pollhit", 2'b10, a, (model_mem[a] & m) | (d & ~m), m, -1, 32'h0, 0, 1'($urandom));
      else if (r == 9) apply_stimulus("rnd_poll", 2'b10, a, d, m, -1, 32'h0, $urandom_range(0, 2), 1'($urandom));
      else             apply_stimulus("rnd_bad", 2'b11, a, d, m, -1, 32'h0, $urandom_range(0, 2), 1'($urandom));
    end

    $display("[TB] reset during poll gap");
    status_val         = 32'h0;
    bus_if.cmd_valid_i = 1'b1;
    bus_if.cmd_op_i    = 2'b10;
    bus_if.cmd_addr_i  = STATUS_ADDR;
    bus_if.cmd_data_i  = 32'h1;
    bus_if.cmd_mask_i  = 32'h1;
    tick();
    bus_if.cmd_valid_i = 1'b0;
    check_output("rst_poll_first_rd", bus_if.rd_en_o, 1'b1);
    tick(); tick();
    rst_n = 1'b0;
    #1;
    check_output("rst_async_ready", bus_if.cmd_ready_o, 1'b0);
    check_output("rst_async_valid", bus_if.rsp_valid_o, 1'b0);
    check_output("rst_async_strobes", {30'h0, bus_if.wr_en_o, bus_if.rd_en_o}, 32'h0);
    check_output("rst_async_addr", {24'h0, bus_if.addr_o}, 32'h0);
    check_output("rst_async_data", bus_if.rsp_data_o, 32'h0);
    check_output("rst_async_err", bus_if.rsp_err_o, 1'b0);
    for (int i = 0; i < 256; i++) model_mem[i] = '0;
    status_val = 32'h1;
    tick(); tick();
    rst_n = 1'b1;
    b2b_wait = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus_if.rsp_valid_o || bus_if.rd_en_o || bus_if.wr_en_o) b2b_wait++;
    end
    check_output("rst_no_activity", b2b_wait, 0);
    check_output("rst_ready_after", bus_if.cmd_ready_o, 1'b1);
    apply_stimulus("rd_after_rst", 2'b01, CTRL_ADDR, 32'h0, 32'h0, -1, 32'h0, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
